sample_stream_feeder: RTL and testbench
=======================================

Name: sample_stream_feeder

Overview:
- Producer end of the x_bus/y_bus/en/cout sample interface consumed by the regression coefficient calculator.
- Holds a dataset of N (x, y) pairs in internal storage, loaded through a simple write port.
- On start, replays the full dataset once per pass. A pass begins each time the calculator raises coeff_ready.
- Stops when the calculator reports coeff_done.

Parameters:
- DATA_W, 20, width of x_bus/y_bus samples (signed fixed-point, passed through unmodified).
- N_SAMPLES, 150, number of (x, y) pairs per pass; must be ≥2.
- ADDR_W, 8, index width; 2^ADDR_W ≥ N_SAMPLES.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset; sampled on rising clk.
- wr_en  in  1  write one pair into storage; accepted only in IDLE and DONE.
- wr_addr  in  ADDR_W  write index; writes with wr_addr ≥ N_SAMPLES are dropped.
- wr_x  in  DATA_W  x sample to write.
- wr_y  in  DATA_W  y sample to write.
- start  in  1  begin a feed session; honoured only in IDLE or DONE.
- coeff_ready  in  1  from calculator; a rising edge requests one full pass.
- coeff_done  in  1  from calculator; coefficients final, end session.
- x_bus  out  DATA_W  x sample; valid when en=1.
- y_bus  out  DATA_W  y sample; valid when en=1.
- en  out  1  sample-valid strobe to calculator.
- cout  out  1  high with en on the last sample (index N_SAMPLES-1) of each pass.
- busy  out  1  high in WAIT_RDY and STREAM.
- done  out  1  high in DONE.
- pass_cnt  out  4  completed passes this session; saturates at 15.

Behaviour:
- Reset (rst=0 at rising clk):
  - State goes to IDLE.
  - x_bus, y_bus, en, cout, busy, done and pass_cnt all go to 0.
  - Sample index and the coeff_ready edge register are cleared.
  - Storage contents are NOT cleared.
  - Reset mid-stream aborts the pass: en drops to 0 the next cycle, with no cout.
- All outputs are registered.
- ready_rise = coeff_ready & ~coeff_ready_q, where coeff_ready_q is coeff_ready registered.
- Writes: memory[wr_addr] <= {wr_x, wr_y} on wr_en, only in IDLE or DONE. Writes in other states are ignored.
- FSM states:
  - IDLE:
    - start=1 → WAIT_RDY next cycle; pass_cnt<=0.
    - start and wr_en in the same cycle: the write lands, then the transition happens.
  - WAIT_RDY: busy=1, en=0.
    - coeff_done=1 → DONE. coeff_done has priority over ready_rise in the same cycle.
    - Otherwise ready_rise → STREAM; idx<=0.
  - STREAM: busy=1.
    - One sample per cycle, no gaps: en=1, x_bus/y_bus = memory[idx].
    - cout=1 exactly when idx = N_SAMPLES-1.
    - The first en cycle is the cycle after the cycle where ready_rise was sampled.
    - Pass length is exactly N_SAMPLES consecutive en cycles.
    - On the last sample: pass_cnt += 1 (saturating), then → WAIT_RDY.
    - coeff_ready edges and coeff_done during STREAM are ignored; the edge register still tracks, so a level held high does not retrigger.
  - DONE: done=1, busy=0, en=0.
    - start → WAIT_RDY; pass_cnt<=0.
    - Otherwise hold.
- In states other than STREAM, x_bus/y_bus hold their last driven value.
- Wrap-around:
  - idx counts 0..N_SAMPLES-1 and never reaches N_SAMPLES.
  - The index resets per pass, so there is no carry between passes.
- The calculator must drop coeff_ready and raise it again to request the next pass. Holding coeff_ready high yields exactly one pass.
- Data path: samples are passed bit-exact; no arithmetic on x/y.

Decomposition:
- Shared package holds:
  - DATA_W and N_SAMPLES defaults, shared with the coefficient calculator.
  - FSM state encoding (IDLE=0, WAIT_RDY=1, STREAM=2, DONE=3).
- One sub-module: sample_store, a dual-array register file with one synchronous write port and one read port.
  - Read data is registered so it aligns with en.
  - The read address is driven one cycle ahead (idx_next) so data and en appear in the same cycle.

Test Plan:
1. Load and single pass, N_SAMPLES=4.
   - Stimulus: load x={1,2,3,4}, y={10,20,30,40}; start; coeff_ready rises at cycle t.
   - Response: en=1 on cycles t+1..t+4 with x_bus=1,2,3,4 and y_bus=10..40; cout=1 only at t+4; pass_cnt=1; busy stays 1.
2. Two passes then done.
   - Stimulus: coeff_ready pulses twice (low gap between them); coeff_done=1 afterwards.
   - Response: two identical 4-sample bursts, each ending in cout; pass_cnt=2; done=1 one cycle after coeff_done; en=0 thereafter.
3. Held ready and ignored edges.
   - Stimulus: coeff_ready held high for 20 cycles; separately, pulse coeff_ready mid-stream.
   - Response: held-high level produces exactly one pass; the mid-stream pulse adds no extra pass and does not truncate the current one.
4. Reset mid-stream.
   - Stimulus: rst=0 for one cycle while idx=2.
   - Response: next cycle en=0, cout never asserted, state IDLE, pass_cnt=0.
   - Follow-up: start plus a new ready edge replays from x=1 (storage retained).
5. Write gating.
   - Stimulus: wr_en with addr=1, x=99 during STREAM; also wr_addr=N_SAMPLES in IDLE.
   - Response: both writes ignored; next pass still outputs x=2 at index 1; no aliasing at index 0.
6. Priority.
   - Stimulus: coeff_done and a coeff_ready rising edge in the same WAIT_RDY cycle.
   - Response: → DONE, no en burst.

Source files
------------

// File: rtl/sample_stream_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sample_stream_feeder_pkg
//  Description : Shared defaults and FSM encoding for the sample stream
//                feeder and the coefficient calculator it drives.
//  Revision    : 1.0 - initial release
// ============================================================================
package sample_stream_feeder_pkg;

    // Sample width and dataset size shared with the coefficient calculator
    localparam int DATA_W_DEF    = 20;
    localparam int N_SAMPLES_DEF = 150;
    localparam int ADDR_W_DEF    = 8;

    // Width of the completed-pass counter
    localparam int PASS_W = 4;

    // Feeder session states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_STREAM   = 2'd2,
        ST_DONE     = 2'd3
    } feeder_state_e;

    // Saturating increment of the pass counter
    function automatic logic [PASS_W-1:0] pass_inc(input logic [PASS_W-1:0] cnt);
        if (cnt == {PASS_W{1'b1}}) begin
            return cnt;
        end
        return cnt + PASS_W'(1);
    endfunction

endpackage : sample_stream_feeder_pkg
`default_nettype wire

// File: rtl/sample_stream_feeder_sample_store.sv
`default_nettype none
// ============================================================================
//  Module      : sample_store
//  Description : Dual-array (x, y) register file with one synchronous write
//                port and one registered read port. Only the read register is
//                reset; the stored dataset survives reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_store #(
    parameter int DATA_W    = 20,
    parameter int N_SAMPLES = 150,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_i,      // synchronous, active-low
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_x_i,
    input  logic [DATA_W-1:0] wr_y_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_x_o,
    output logic [DATA_W-1:0] rd_y_o
);

    // Index width actually needed by the arrays; never wider than ADDR_W
    localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;

    logic [DATA_W-1:0] mem_x_q [N_SAMPLES];
    logic [DATA_W-1:0] mem_y_q [N_SAMPLES];

    logic [DATA_W-1:0] rd_x_q;
    logic [DATA_W-1:0] rd_y_q;

    logic              wr_ok;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    // Out-of-range writes are dropped rather than aliased onto low entries
    assign wr_ok  = wr_en_i && (32'(wr_addr_i) < N_SAMPLES);
    assign wr_idx = wr_addr_i[IDX_W-1:0];
    assign rd_idx = rd_addr_i[IDX_W-1:0];

    // Storage write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_x_q[wr_idx] <= wr_x_i;
            mem_y_q[wr_idx] <= wr_y_i;
        end
    end

    // Registered read so data lines up with the registered en strobe; holds otherwise
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            rd_x_q <= '0;
            rd_y_q <= '0;
        end else if (rd_en_i && (32'(rd_addr_i) < N_SAMPLES)) begin
            rd_x_q <= mem_x_q[rd_idx];
            rd_y_q <= mem_y_q[rd_idx];
        end
    end

    assign rd_x_o = rd_x_q;
    assign rd_y_o = rd_y_q;

endmodule : sample_store
`default_nettype wire

// File: rtl/sample_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : sample_stream_feeder
//  Description : Producer side of the x_bus/y_bus/en/cout sample interface.
//                Replays a stored dataset once per coeff_ready rising edge
//                until the calculator signals coeff_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_stream_feeder
    import sample_stream_feeder_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_x,
    input  logic [DATA_W-1:0] wr_y,
    input  logic              start,
    input  logic              coeff_ready,
    input  logic              coeff_done,
    output logic [DATA_W-1:0] x_bus,
    output logic [DATA_W-1:0] y_bus,
    output logic              en,
    output logic              cout,
    output logic              busy,
    output logic              done,
    output logic [PASS_W-1:0] pass_cnt
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SAMPLES - 1);

    feeder_state_e     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] idx_inc;
    logic [ADDR_W-1:0] idx_next;
    logic              rd_en;
    logic              en_q, en_d;
    logic              cout_q, cout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic              coeff_ready_q;
    logic              ready_rise;
    logic              store_wr_en;

    assign ready_rise  = coeff_ready & ~coeff_ready_q;
    assign idx_inc     = idx_q + ADDR_W'(1);
    // The dataset may only change while no session is consuming it
    assign store_wr_en = wr_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state, next-index and registered-output decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        idx_next   = idx_q;
        rd_en      = 1'b0;
        en_d       = 1'b0;
        cout_d     = 1'b0;
        pass_cnt_d = pass_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_WAIT_RDY;
                    pass_cnt_d = '0;
                end
            end

            ST_WAIT_RDY: begin
                if (coeff_done) begin
                    state_d = ST_DONE;
                end else if (ready_rise) begin
                    // Address the first sample now so it appears together with en
                    state_d  = ST_STREAM;
                    idx_d    = '0;
                    idx_next = '0;
                    rd_en    = 1'b1;
                    en_d     = 1'b1;
                    cout_d   = (LAST_IDX == '0);
                end
            end

            ST_STREAM: begin
                if (idx_q == LAST_IDX) begin
                    state_d    = ST_WAIT_RDY;
                    idx_d      = '0;
                    pass_cnt_d = pass_inc(pass_cnt_q);
                end else begin
                    idx_d    = idx_inc;
                    idx_next = idx_inc;
                    rd_en    = 1'b1;
                    en_d     = 1'b1;
                    cout_d   = (idx_inc == LAST_IDX);
                end
            end

            ST_DONE: begin
                if (start) begin
                    state_d    = ST_WAIT_RDY;
                    pass_cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_WAIT_RDY) || (state_d == ST_STREAM);
        done_d = (state_d == ST_DONE);
    end

    // State, index and status registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            en_q          <= 1'b0;
            cout_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_cnt_q    <= '0;
            coeff_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            en_q          <= en_d;
            cout_q        <= cout_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_cnt_q    <= pass_cnt_d;
            coeff_ready_q <= coeff_ready;
        end
    end

    sample_store #(
        .DATA_W    (DATA_W),
        .N_SAMPLES (N_SAMPLES),
        .ADDR_W    (ADDR_W)
    ) u_store (
        .clk       (clk),
        .rst_i     (rst),
        .wr_en_i   (store_wr_en),
        .wr_addr_i (wr_addr),
        .wr_x_i    (wr_x),
        .wr_y_i    (wr_y),
        .rd_en_i   (rd_en),
        .rd_addr_i (idx_next),
        .rd_x_o    (x_bus),
        .rd_y_o    (y_bus)
    );

    assign en       = en_q;
    assign cout     = cout_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass_cnt = pass_cnt_q;

endmodule : sample_stream_feeder
`default_nettype wire

// File: tb/tb_sample_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_stream_feeder
//  Description : Scoreboard bench for sample_stream_feeder with N_SAMPLES=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_stream_feeder;

    localparam int DATA_W    = 20;
    localparam int N_SAMPLES = 4;
    localparam int ADDR_W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_x;
    logic [DATA_W-1:0] wr_y;
    logic              start;
    logic              coeff_ready;
    logic              coeff_done;
    logic [DATA_W-1:0] x_bus;
    logic [DATA_W-1:0] y_bus;
    logic              en;
    logic              cout;
    logic              busy;
    logic              done;
    logic [3:0]        pass_cnt;

    int checks = 0;
    int errors = 0;

    // Expected beat: {cout, x, y}
    logic [2*DATA_W:0] exp_q [$];

    // Hand-entered dataset
    logic [DATA_W-1:0] ref_x [N_SAMPLES];
    logic [DATA_W-1:0] ref_y [N_SAMPLES];

    sample_stream_feeder #(
        .DATA_W    (DATA_W),
        .N_SAMPLES (N_SAMPLES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .start       (start),
        .coeff_ready (coeff_ready),
        .coeff_done  (coeff_done),
        .x_bus       (x_bus),
        .y_bus       (y_bus),
        .en          (en),
        .cout        (cout),
        .busy        (busy),
        .done        (done),
        .pass_cnt    (pass_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every en beat is matched against the head of the scoreboard
    always @(negedge clk) begin
        logic [2*DATA_W:0] e;
        if (en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_en: x=%0d y=%0d cout=%0b, no beat expected", x_bus, y_bus, cout);
            end else begin
                e = exp_q.pop_front();
                if ({cout, x_bus, y_bus} !== e) begin
                    errors++;
                    $display("FAIL beat: got cout=%0b x=%0d y=%0d, expected cout=%0b x=%0d y=%0d",
                             cout, x_bus, y_bus, e[2*DATA_W], e[2*DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_stream: got %0b, expected 1", busy);
            end
        end else if (cout) begin
            checks++;
            errors++;
            $display("FAIL cout_without_en: cout=1 while en=0");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int a, input int x, input int y);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_x    = DATA_W'(x);
        wr_y    = DATA_W'(y);
        tick();
        wr_en   = 1'b0;
    endtask

    // Queue the first n beats of one pass from the reference dataset
    task automatic push_beats(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == N_SAMPLES - 1) ? 1'b1 : 1'b0, ref_x[i], ref_y[i]});
        end
    endtask

    task automatic ready_pulse();
        coeff_ready = 1'b1;
        tick();
        coeff_ready = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        ref_x[0] = 1;  ref_x[1] = 2;  ref_x[2] = 3;  ref_x[3] = 4;
        ref_y[0] = 10; ref_y[1] = 20; ref_y[2] = 30; ref_y[3] = 40;

        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0;
        start = 1'b0; coeff_ready = 1'b0; coeff_done = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_en", 32'(en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass_cnt", 32'(pass_cnt), 0);
        chk("rst_x_bus", 32'(x_bus), 0);
        rst = 1'b1;
        tick();

        // 1: load and single pass; last write shares its cycle with start
        wr(0, 1, 10);
        wr(1, 2, 20);
        wr(2, 3, 30);
        start = 1'b1;
        wr(3, 4, 40);
        start = 1'b0;
        chk("t1_busy_wait", 32'(busy), 1);
        chk("t1_en_wait", 32'(en), 0);
        push_beats(N_SAMPLES);
        ready_pulse();
        repeat (5) tick();
        chk("t1_pass_cnt", 32'(pass_cnt), 1);
        chk("t1_busy_after", 32'(busy), 1);
        chk("t1_queue_drained", 32'(exp_q.size()), 0);

        // 2: second pass, then coeff_done
        repeat (2) tick();
        push_beats(N_SAMPLES);
        ready_pulse();
        repeat (5) tick();
        chk("t2_pass_cnt", 32'(pass_cnt), 2);
        coeff_done = 1'b1;
        tick();
        coeff_done = 1'b0;
        chk("t2_done", 32'(done), 1);
        chk("t2_busy", 32'(busy), 0);
        repeat (4) tick();
        chk("t2_en_after_done", 32'(en), 0);
        chk("t2_pass_cnt_held", 32'(pass_cnt), 2);

        // 3a: held-high ready gives exactly one pass
        do_start();
        chk("t3_pass_cnt_cleared", 32'(pass_cnt), 0);
        chk("t3_done_cleared", 32'(done), 0);
        push_beats(N_SAMPLES);
        coeff_ready = 1'b1;
        repeat (20) tick();
        coeff_ready = 1'b0;
        chk("t3_held_pass_cnt", 32'(pass_cnt), 1);
        tick();

        // 3b: a pulse during the stream neither adds nor truncates a pass
        push_beats(N_SAMPLES);
        ready_pulse();
        tick();
        ready_pulse();
        repeat (6) tick();
        chk("t3_mid_pulse_pass_cnt", 32'(pass_cnt), 2);
        chk("t3_queue_drained", 32'(exp_q.size()), 0);

        // 4: reset while index 2 is on the bus
        push_beats(3);
        ready_pulse();
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t4_en_after_rst", 32'(en), 0);
        chk("t4_pass_cnt", 32'(pass_cnt), 0);
        chk("t4_busy_idle", 32'(busy), 0);
        chk("t4_done_idle", 32'(done), 0);
        chk("t4_queue_drained", 32'(exp_q.size()), 0);
        // Storage retained: a fresh session replays from x=1
        do_start();
        push_beats(N_SAMPLES);
        ready_pulse();
        repeat (5) tick();
        chk("t4_replay_pass_cnt", 32'(pass_cnt), 1);

        // 5: write during STREAM ignored, out-of-range write in IDLE dropped
        push_beats(N_SAMPLES);
        ready_pulse();
        wr(1, 99, 990);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        wr(N_SAMPLES, 777, 888);
        do_start();
        push_beats(N_SAMPLES);
        ready_pulse();
        repeat (5) tick();
        chk("t5_pass_cnt", 32'(pass_cnt), 1);
        chk("t5_queue_drained", 32'(exp_q.size()), 0);

        // 6: coeff_done beats a simultaneous ready edge
        coeff_done  = 1'b1;
        coeff_ready = 1'b1;
        tick();
        coeff_done  = 1'b0;
        coeff_ready = 1'b0;
        chk("t6_done", 32'(done), 1);
        chk("t6_en", 32'(en), 0);
        repeat (6) tick();
        chk("t6_pass_cnt", 32'(pass_cnt), 1);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sample_stream_feeder
`default_nettype wire
